// File: rtl/traffic_pkg.sv
// traffic_pkg: approach state encoding and approach count shared with the phase controller.
package traffic_pkg;
    localparam int NUM_APPR = 4;
    typedef enum logic [1:0] {RED, GREEN, AMBER, CLEAR} appr_state_e;
endpackage

// File: rtl/approach_fsm.sv
// approach_fsm: per-approach lamp state machine with amber/all-red interval counter and registered lamp decode.
module approach_fsm
    import traffic_pkg::*;
#(
    parameter int AMBER_TICKS  = 3,
    parameter int ALLRED_TICKS = 2,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic lg_i,
    input  logic sg_i,
    input  logic rg_i,
    input  logic go_i,
    input  logic fault_i,
    input  logic flash_i,
    output logic active_o,
    output logic red_o,
    output logic amber_o,
    output logic lg_o,
    output logic sg_o,
    output logic rg_o,
    output logic busy_o
);
    appr_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic red_q, amber_q, lg_q, sg_q, rg_q, busy_q;
    logic last_tick;

    assign last_tick = tick && cnt_q == CNT_W'(1);
    // Non-RED next cycle, excluding RED->GREEN entry, so the interlock never depends on go_i.
    assign active_o = state_q == GREEN || state_q == AMBER || (state_q == CLEAR && !last_tick);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RED:   if (go_i) state_d = GREEN;
            GREEN: if (!(lg_i || sg_i || rg_i)) begin
                state_d = AMBER;
                cnt_d   = CNT_W'(AMBER_TICKS);
            end
            AMBER: if (tick) begin
                state_d = last_tick ? CLEAR : AMBER;
                cnt_d   = last_tick ? CNT_W'(ALLRED_TICKS) : cnt_q - CNT_W'(1);
            end
            default: if (tick) begin
                state_d = last_tick ? RED : CLEAR;
                cnt_d   = last_tick ? '0 : cnt_q - CNT_W'(1);
            end
        endcase
        if (fault_i) begin
            state_d = RED;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RED;
            cnt_q   <= '0;
            red_q   <= 1'b1;
            amber_q <= 1'b0;
            lg_q    <= 1'b0;
            sg_q    <= 1'b0;
            rg_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            red_q   <= !fault_i && (state_d == RED || state_d == CLEAR);
            amber_q <= fault_i ? flash_i : state_d == AMBER;
            lg_q    <= state_d == GREEN && lg_i;
            sg_q    <= state_d == GREEN && sg_i;
            rg_q    <= state_d == GREEN && rg_i;
            busy_q  <= state_d == AMBER || state_d == CLEAR;
        end
    end

    assign red_o   = red_q;
    assign amber_o = amber_q;
    assign lg_o    = lg_q;
    assign sg_o    = sg_q;
    assign rg_o    = rg_q;
    assign busy_o  = busy_q;
endmodule

// File: rtl/signal_lamp_sequencer.sv
// signal_lamp_sequencer: drives approach lamps from phase-controller requests with clearance intervals,
// single-green interlock, input checking and a latched flashing-amber fault mode.
module signal_lamp_sequencer
    import traffic_pkg::*;
#(
    parameter int AMBER_TICKS   = 3,
    parameter int ALLRED_TICKS  = 2,
    parameter int FAULT_PERSIST = 4,
    parameter int CNT_W         = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [NUM_APPR-1:0] lg,
    input  logic [NUM_APPR-1:0] sg,
    input  logic [NUM_APPR-1:0] rg,
    input  logic [NUM_APPR-1:0] r,
    input  logic                fault_clr,
    output logic [NUM_APPR-1:0] lamp_red,
    output logic [NUM_APPR-1:0] lamp_amber,
    output logic [NUM_APPR-1:0] lamp_lg,
    output logic [NUM_APPR-1:0] lamp_sg,
    output logic [NUM_APPR-1:0] lamp_rg,
    output logic                fault,
    output logic                busy
);
    localparam int VW = $clog2(FAULT_PERSIST + 1);

    logic [NUM_APPR-1:0] greq, active, go, busy_v;
    logic [VW-1:0] viol_q, viol_d;
    logic fault_q, fault_d, flash_q, flash_d;
    logic multi, illegal;

    assign greq    = lg | sg | rg;
    assign multi   = |(greq & (greq - NUM_APPR'(1)));
    assign illegal = |(r & greq) || (|(~greq & ~r) && |{lg, sg, rg, r}) || multi;

    always_comb begin
        viol_d  = illegal ? (viol_q == VW'(FAULT_PERSIST) ? viol_q : viol_q + VW'(1)) : '0;
        fault_d = fault_q ? !(fault_clr && !illegal) : illegal && viol_q == VW'(FAULT_PERSIST - 1);
        // Flash starts low when fault latches so the first tick afterwards lights amber.
        flash_d = fault_d && fault_q ? flash_q ^ tick : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_q  <= '0;
            fault_q <= 1'b0;
            flash_q <= 1'b0;
        end else begin
            viol_q  <= viol_d;
            fault_q <= fault_d;
            flash_q <= flash_d;
        end
    end

    // A single legal request may enter GREEN on the same clk the previous owner returns to RED.
    assign go = greq & {NUM_APPR{greq != '0 && !multi && active == '0 && !fault_d}};

    for (genvar i = 0; i < NUM_APPR; i++) begin : g_appr
        approach_fsm #(
            .AMBER_TICKS (AMBER_TICKS),
            .ALLRED_TICKS(ALLRED_TICKS),
            .CNT_W       (CNT_W)
        ) u_fsm (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .lg_i    (lg[i]),
            .sg_i    (sg[i]),
            .rg_i    (rg[i]),
            .go_i    (go[i]),
            .fault_i (fault_d),
            .flash_i (flash_d),
            .active_o(active[i]),
            .red_o   (lamp_red[i]),
            .amber_o (lamp_amber[i]),
            .lg_o    (lamp_lg[i]),
            .sg_o    (lamp_sg[i]),
            .rg_o    (lamp_rg[i]),
            .busy_o  (busy_v[i])
        );
    end

    assign fault = fault_q;
    assign busy  = |busy_v;
endmodule
